// File: rtl/hazard_detect_unit.sv
// hazard_detect_unit
// Producer side of the operand-forwarding interface for a 5-stage pipeline.
// It tracks {regd, regwrite, memread} for each in-flight instruction through
// the ID/EX, EX/MEM and MEM/WB slots, and it drives the forwarding unit from
// those registered flags.
// It detects load-use hazards and raises a one-cycle stall with a bubble.
// A branch flush squashes the instruction leaving ID.
// Optional build macro: HAZARD_STALL_CNT_EN adds the stall_cnt_o counter.
module hazard_detect_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  id_regs,
    input  logic [4:0]  id_regt,
    input  logic        id_uses_rt,
    input  logic [4:0]  id_regd,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        flush_i,
    output logic        pc_write_o,
    output logic        ifid_write_o,
    output logic        bubble_o,
    output logic [4:0]  idex_regd,
    output logic        idex_regwrite,
    output logic        idex_memread,
    output logic        regwrite_mem,
    output logic [4:0]  exmem_regd,
    output logic        regwrite_wb,
`ifdef HAZARD_STALL_CNT_EN
    output logic [4:0]  memwb_regd,
    output logic [31:0] stall_cnt_o
`else
    output logic [4:0]  memwb_regd
`endif
);

    logic [4:0] idex_regd_q,     idex_regd_d;
    logic       idex_regwrite_q, idex_regwrite_d;
    logic       idex_memread_q,  idex_memread_d;
    logic [4:0] exmem_regd_q,    exmem_regd_d;
    logic       exmem_regwrite_q, exmem_regwrite_d;
    logic       exmem_memread_q, exmem_memread_d;
    logic [4:0] memwb_regd_q,    memwb_regd_d;
    logic       memwb_regwrite_q, memwb_regwrite_d;

    logic hazard;
    logic stall;
    logic bubble;

    // Load-use detection: a load in ID/EX whose target is read by ID.
    // $0 is never a real dependency. A flush takes priority over the stall.
    always_comb begin
        hazard = 1'b0;
        if (idex_memread_q && (idex_regd_q != 5'd0)) begin
            if ((idex_regd_q == id_regs) ||
                (id_uses_rt && (idex_regd_q == id_regt))) begin
                hazard = 1'b1;
            end
        end
        stall  = hazard && !flush_i;
        bubble = stall || flush_i;
    end

    assign pc_write_o   = !stall;
    assign ifid_write_o = !stall;
    assign bubble_o     = bubble;

    // Next-state slot logic. The back end advances every cycle.
    // A bubble enters ID/EX as all zeroes so that forwarding never matches it.
    always_comb begin
        idex_regd_d      = id_regd;
        idex_regwrite_d  = id_regwrite;
        idex_memread_d   = id_memread;
        if (bubble) begin
            idex_regd_d     = 5'd0;
            idex_regwrite_d = 1'b0;
            idex_memread_d  = 1'b0;
        end
        exmem_regd_d     = idex_regd_q;
        exmem_regwrite_d = idex_regwrite_q;
        exmem_memread_d  = idex_memread_q;
        memwb_regd_d     = exmem_regd_q;
        memwb_regwrite_d = exmem_regwrite_q;
    end

    // Slot registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idex_regd_q      <= 5'd0;
            idex_regwrite_q  <= 1'b0;
            idex_memread_q   <= 1'b0;
            exmem_regd_q     <= 5'd0;
            exmem_regwrite_q <= 1'b0;
            exmem_memread_q  <= 1'b0;
            memwb_regd_q     <= 5'd0;
            memwb_regwrite_q <= 1'b0;
        end else begin
            idex_regd_q      <= idex_regd_d;
            idex_regwrite_q  <= idex_regwrite_d;
            idex_memread_q   <= idex_memread_d;
            exmem_regd_q     <= exmem_regd_d;
            exmem_regwrite_q <= exmem_regwrite_d;
            exmem_memread_q  <= exmem_memread_d;
            memwb_regd_q     <= memwb_regd_d;
            memwb_regwrite_q <= memwb_regwrite_d;
        end
    end

    assign idex_regd     = idex_regd_q;
    assign idex_regwrite = idex_regwrite_q;
    assign idex_memread  = idex_memread_q;
    assign exmem_regd    = exmem_regd_q;
    assign regwrite_mem  = exmem_regwrite_q;
    assign memwb_regd    = memwb_regd_q;
    assign regwrite_wb   = memwb_regwrite_q;

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Count load-use stall cycles only; flush-only bubbles are not stalls.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register; it wraps naturally at 32 bits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

    // EX/MEM memread is carried for completeness but not exported.
    logic unused_exmem_memread;
    assign unused_exmem_memread = exmem_memread_q;
`else
    logic unused_exmem_memread;
    assign unused_exmem_memread = exmem_memread_q;
`endif

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Testbench for hazard_detect_unit: a scoreboard fed by a pipeline model plus directed checks.
module tb_hazard_detect_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [4:0]  id_regs, id_regt, id_regd;
    logic        id_uses_rt, id_regwrite, id_memread, flush_i;
    logic        pc_write_o, ifid_write_o, bubble_o;
    logic [4:0]  idex_regd, exmem_regd, memwb_regd;
    logic        idex_regwrite, idex_memread, regwrite_mem, regwrite_wb;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    hazard_detect_unit dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_regs(id_regs), .id_regt(id_regt), .id_uses_rt(id_uses_rt),
        .id_regd(id_regd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .flush_i(flush_i),
        .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .bubble_o(bubble_o),
        .idex_regd(idex_regd), .idex_regwrite(idex_regwrite), .idex_memread(idex_memread),
        .regwrite_mem(regwrite_mem), .exmem_regd(exmem_regd),
        .regwrite_wb(regwrite_wb),
`ifdef HAZARD_STALL_CNT_EN
        .memwb_regd(memwb_regd),
        .stall_cnt_o(stall_cnt_o)
`else
        .memwb_regd(memwb_regd)
`endif
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    int checks = 0;
    int errors = 0;

    // Pipeline reference model.
    logic [4:0]  m_idex_rd = 0, m_exmem_rd = 0, m_memwb_rd = 0;
    logic        m_idex_rw = 0, m_idex_mr = 0, m_exmem_rw = 0, m_exmem_mr = 0, m_memwb_rw = 0;
    logic [31:0] m_cnt = 0;
    logic        m_stall = 0, m_bub = 0;

    function automatic logic [31:0] pack(input logic pc, input logic ifw, input logic bub,
                                         input logic [4:0] ird, input logic irw, input logic imr,
                                         input logic mrw, input logic [4:0] erd,
                                         input logic wrw, input logic [4:0] wrd);
        return {10'd0, pc, ifw, bub, ird, irw, imr, mrw, erd, wrw, wrd};
    endfunction

    task automatic compare(input logic [31:0] obs);
        sb_t e;
        e = sb_q.pop_front();
        checks++;
        assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
        end
    endtask

    task automatic set_in(input logic rst, input logic flush, input logic [4:0] rs,
                          input logic [4:0] rt, input logic urt, input logic [4:0] rd,
                          input logic rw, input logic mr);
        logic hz;
        rst_i = rst; flush_i = flush; id_regs = rs; id_regt = rt; id_uses_rt = urt;
        id_regd = rd; id_regwrite = rw; id_memread = mr;
        hz = m_idex_mr && (m_idex_rd != 5'd0) &&
             ((m_idex_rd == rs) || (urt && (m_idex_rd == rt)));
        m_stall = hz && !flush;
        m_bub   = m_stall || flush;
        sb_q.push_back('{"pipe", pack(!m_stall, !m_stall, m_bub, m_idex_rd, m_idex_rw, m_idex_mr,
                                      m_exmem_rw, m_exmem_rd, m_memwb_rw, m_memwb_rd)});
`ifdef HAZARD_STALL_CNT_EN
        sb_q.push_back('{"stall_cnt", m_cnt});
`endif
        #2;
    endtask

    task automatic check_all();
        compare(pack(pc_write_o, ifid_write_o, bubble_o, idex_regd, idex_regwrite, idex_memread,
                     regwrite_mem, exmem_regd, regwrite_wb, memwb_regd));
`ifdef HAZARD_STALL_CNT_EN
        compare(stall_cnt_o);
`endif
    endtask

    task automatic expect_now(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        sb_q.push_back('{tag, exp});
        compare(obs);
    endtask

    task automatic tick();
        @(posedge clk_i);
        if (rst_i) begin
            {m_idex_rd, m_idex_rw, m_idex_mr} = '0;
            {m_exmem_rd, m_exmem_rw, m_exmem_mr} = '0;
            {m_memwb_rd, m_memwb_rw} = '0;
            m_cnt = 0;
        end else begin
            m_memwb_rd = m_exmem_rd; m_memwb_rw = m_exmem_rw;
            m_exmem_rd = m_idex_rd;  m_exmem_rw = m_idex_rw; m_exmem_mr = m_idex_mr;
            if (m_bub) {m_idex_rd, m_idex_rw, m_idex_mr} = '0;
            else {m_idex_rd, m_idex_rw, m_idex_mr} = {id_regd, id_regwrite, id_memread};
            if (m_stall) m_cnt = m_cnt + 1;
        end
        #1;
    endtask

    // Convenience: one fully model-checked cycle.
    task automatic cyc(input logic flush, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic [4:0] rd, input logic rw, input logic mr);
        set_in(1'b0, flush, rs, rt, urt, rd, rw, mr);
        check_all();
        tick();
    endtask

    initial begin
        // Reset for 2 cycles with a live instruction in ID; the first cycle precedes any edge.
        set_in(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        sb_q = {};
        tick();
        set_in(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        check_all();
        tick();
        set_in(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        check_all();
        expect_now("rst_outputs", {idex_regd, exmem_regd, memwb_regd, idex_regwrite,
                   idex_memread, regwrite_mem, regwrite_wb, pc_write_o, bubble_o}, 32'h0000_0002);
        tick();

        // Load-use on rs: lw $8, then a consumer of $8.
        cyc(1'b0, 5'd1, 5'd2, 1'b0, 5'd8, 1'b1, 1'b1);
        set_in(1'b0, 1'b0, 5'd8, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
        check_all();
        expect_now("lu_stall", {pc_write_o, ifid_write_o, bubble_o}, 32'd1);
        tick();
        set_in(1'b0, 1'b0, 5'd8, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
        check_all();
        expect_now("lu_release", {idex_regwrite, pc_write_o, bubble_o}, 32'd2);
        tick();
        set_in(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        check_all();
        expect_now("lu_memwb", {regwrite_wb, memwb_regd}, {26'd0, 1'b1, 5'd8});
        tick();

        // rt gating.
        cyc(1'b0, 5'd0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
        set_in(1'b0, 1'b0, 5'd1, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0);
        check_all();
        expect_now("rt_unused_nostall", pc_write_o, 32'd1);
        tick();
        cyc(1'b0, 5'd0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
        set_in(1'b0, 1'b0, 5'd1, 5'd9, 1'b1, 5'd11, 1'b1, 1'b0);
        check_all();
        expect_now("rt_used_stall", pc_write_o, 32'd0);
        tick();
        cyc(1'b0, 5'd1, 5'd9, 1'b1, 5'd11, 1'b1, 1'b0);

        // Load to $0 never stalls.
        cyc(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        set_in(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd2, 1'b1, 1'b0);
        check_all();
        expect_now("r0_nostall", {pc_write_o, bubble_o}, 32'd2);
        tick();

        // Flush overrides a load-use hazard.
        cyc(1'b0, 5'd0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
        set_in(1'b0, 1'b1, 5'd4, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
        check_all();
        expect_now("flush_hazard", {pc_write_o, bubble_o}, 32'd3);
        tick();
        set_in(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        check_all();
        expect_now("flush_clear", {idex_regd, idex_regwrite, idex_memread}, 32'd0);
        tick();
        // Plain flush with no hazard.
        cyc(1'b1, 5'd3, 5'd0, 1'b0, 5'd13, 1'b1, 1'b1);

        // Pipeline shift: add $3, add $7.
        cyc(1'b0, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        cyc(1'b0, 5'd1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);
        set_in(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        check_all();
        expect_now("shift_a", {exmem_regd, idex_regd, regwrite_mem, idex_regwrite},
                   {20'd0, 5'd3, 5'd7, 1'b1, 1'b1});
        tick();
        set_in(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        check_all();
        expect_now("shift_b", {memwb_regd, exmem_regd, regwrite_wb, regwrite_mem},
                   {20'd0, 5'd3, 5'd7, 1'b1, 1'b1});
        tick();

        // Third load-use stall.
        cyc(1'b0, 5'd0, 5'd0, 1'b0, 5'd15, 1'b1, 1'b1);
        cyc(1'b0, 5'd15, 5'd0, 1'b0, 5'd16, 1'b1, 1'b0);
        cyc(1'b0, 5'd15, 5'd0, 1'b0, 5'd16, 1'b1, 1'b0);
`ifdef HAZARD_STALL_CNT_EN
        expect_now("cnt_three", stall_cnt_o, 32'd3);
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        cyc(1'b0, 5'd0, 5'd0, 1'b0, 5'd17, 1'b1, 1'b1);
        cyc(1'b0, 5'd17, 5'd0, 1'b0, 5'd18, 1'b1, 1'b0);
        expect_now("cnt_wrap", stall_cnt_o, 32'd0);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 40; i++) begin
            cyc(1'($urandom_range(0, 5) == 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
        end

        // Reset while a stall is pending.
        cyc(1'b0, 5'd0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
        set_in(1'b1, 1'b0, 5'd6, 5'd0, 1'b0, 5'd20, 1'b1, 1'b0);
        check_all();
        tick();
        set_in(1'b0, 1'b0, 5'd6, 5'd0, 1'b0, 5'd20, 1'b1, 1'b0);
        check_all();
        expect_now("rst_mid_stall", {idex_regd, idex_memread, exmem_regd, pc_write_o, bubble_o},
                   32'd2);
        tick();
        cyc(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_detect_unit.md
# hazard_detect_unit

Producer side of the operand-forwarding interface in the 5-stage pipelined CPU. Tracks each in-flight instruction's destination register, RegWrite and MemRead flags through ID/EX, EX/MEM and MEM/WB. Drives the forwarding unit's inputs from these registered flags. Detects load-use hazards and issues a one-cycle stall with bubble insertion; branch flushes squash the instruction leaving ID.

## Interface
Parameters:
- none

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- id_regs  in  5  rs field of instruction in ID
- id_regt  in  5  rt field of instruction in ID
- id_uses_rt  in  1  instruction in ID reads rt (R-type, beq, sw)
- id_regd  in  5  destination register of instruction in ID (after RegDst mux)
- id_regwrite  in  1  instruction in ID writes the register file
- id_memread  in  1  instruction in ID is a load
- flush_i  in  1  branch taken; squash the instruction in ID
- pc_write_o  out  1  0 holds PC
- ifid_write_o  out  1  0 holds IF/ID register
- bubble_o  out  1  1 zeroes control into ID/EX
- idex_regd  out  5  ID/EX destination register
- idex_regwrite, idex_memread  out  1 each  ID/EX flags
- regwrite_mem  out  1  EX/MEM RegWrite
- exmem_regd  out  5  EX/MEM destination register
- regwrite_wb  out  1  MEM/WB RegWrite
- memwb_regd  out  5  MEM/WB destination register
- stall_cnt_o  out  32  stall-cycle count (only with HAZARD_STALL_CNT_EN)

## Operation
- Three stage slots: ID/EX, EX/MEM, MEM/WB. Each slot holds {regd[4:0], regwrite, memread}.
- Load-use hazard (combinational) requires all of:
  - idex_memread = 1
  - idex_regd != 0
  - idex_regd == id_regs, or (id_uses_rt = 1 and idex_regd == id_regt)
- stall = hazard AND NOT flush_i.
- pc_write_o = ifid_write_o = NOT stall.
- bubble_o = stall OR flush_i.
- Each rising edge, all three slots update together:
  - ID/EX: loads {0,0,0} if bubble_o = 1, else {id_regd, id_regwrite, id_memread}.
  - EX/MEM: loads the previous ID/EX contents.
  - MEM/WB: loads the previous EX/MEM contents.
- The back end never stalls. EX/MEM and MEM/WB advance every cycle, stalled or not.
- A bubble slot has regwrite = 0 and regd = 0, so it never triggers forwarding.
- A load-use stall lasts exactly one cycle. The next cycle the bubble sits in ID/EX, so the hazard condition is false.
- flush_i overrides a simultaneous hazard: the instruction in ID is squashed instead of stalled (pc_write_o = 1, bubble_o = 1).
- Register $0 never causes a stall, even when a load targets it.

## Timing
- rst_i = 1 at an edge clears all slot fields to 0 and stall_cnt_o to 0. rst_i overrides flush_i and stall.
- After reset: pc_write_o = 1, ifid_write_o = 1, bubble_o = flush_i, all registered outputs 0.
- Hazard-to-stall latency: 0 cycles (combinational from ID inputs and the ID/EX slot).
- Forwarding outputs are registered. An instruction accepted into ID/EX at edge N shows on exmem_regd after edge N+1 and on memwb_regd after edge N+2.
- Reset asserted mid-stall: the bubble and pending load are discarded; normal flow resumes the cycle after rst_i falls.

## Configuration
- HAZARD_STALL_CNT_EN defined:
  - stall_cnt_o exists.
  - Increments by 1 on every edge where stall = 1 and rst_i = 0; wraps from 0xFFFFFFFF to 0.
  - Flush-only bubbles are not counted.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset: hold rst_i 2 cycles with id_regwrite = 1, id_regd = 5 → all registered outputs 0, pc_write_o = 1, bubble_o = 0.
- Load-use: lw $8 enters ID/EX; next ID has id_regs = 8 → pc_write_o = 0, ifid_write_o = 0, bubble_o = 1 for exactly 1 cycle. Next cycle idex_regwrite = 0 and pc_write_o = 1; two edges later memwb_regd = 8, regwrite_wb = 1.
- rt gating: load to $9 in ID/EX, ID has id_regt = 9, id_uses_rt = 0 → no stall. Same with id_uses_rt = 1 → stall.
- $0 and flush: load to $0 with id_regs = 0 → no stall. Load to $4, id_regs = 4, flush_i = 1 → pc_write_o = 1, bubble_o = 1, and ID/EX cleared at the next edge.
- Pipeline shift: issue add $3, add $7 back to back → exmem_regd = 3 while idex_regd = 7; next edge memwb_regd = 3, exmem_regd = 7, with regwrite flags following.
- Counter (macro on): 3 separate load-use stalls plus 2 flushes → stall_cnt_o = 3. Preload count to 0xFFFFFFFF, then one stall → 0.
